// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle for the 3x3 neighbourhood generator.
// The master side is the pixel source; the slave side is the generator.
interface window_gen_3x3_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_pixel;
  logic              out_valid;
  logic [DATA_W-1:0] w1, w2, w3;
  logic [DATA_W-1:0] w4, w5, w6;
  logic [DATA_W-1:0] w7, w8, w9;
  logic              frame_done;

  modport master (
    output in_valid, in_pixel,
    input  out_valid, frame_done,
    input  w1, w2, w3, w4, w5, w6, w7, w8, w9
  );

  modport slave (
    input  in_valid, in_pixel,
    output out_valid, frame_done,
    output w1, w2, w3, w4, w5, w6, w7, w8, w9
  );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift
// window, emitting only windows that lie fully inside the frame.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = 8
) (
  input logic clk,
  input logic rst_n,
  window_gen_3x3_if.slave bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_last, row_last;

  logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  logic [DATA_W-1:0] win_q [9];
  logic              out_valid_q;
  logic              frame_done_q;

  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Asynchronous read gives read-before-write at the shared address.
  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= bus.in_valid &&
                      (row_q >= RW'(2)) &&
                      (col_q >= CW'(2));
      frame_done_q <= bus.in_valid && row_last && col_last;
      if (bus.in_valid) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1_rd;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0_rd;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= bus.in_pixel;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.w1 = win_q[0];
  assign bus.w2 = win_q[1];
  assign bus.w3 = win_q[2];
  assign bus.w4 = win_q[3];
  assign bus.w5 = win_q[4];
  assign bus.w6 = win_q[5];
  assign bus.w7 = win_q[6];
  assign bus.w8 = win_q[7];
  assign bus.w9 = win_q[8];
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: an 8x6 and a 3x3 instance driven with
// directed and random pixel streams against a frame-array model.
module tb_window_gen_3x3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_gen_3x3_if #(.DATA_W(8)) bus_m ();
  window_gen_3x3_if #(.DATA_W(8)) bus_s ();

  window_gen_3x3 #(
    .IMG_WIDTH(8), .IMG_HEIGHT(6), .DATA_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );

  window_gen_3x3 #(
    .IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_W(8)
  ) u_min (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  frm [0:5][0:7];
  logic [71:0] exp_w;
  logic [71:0] got_w;
  logic        got_ov, got_fd;
  bit          w_known;
  int          k;
  int          ov_cnt, fd_cnt;

  task automatic check(input string tag,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input bit sel);
    if (sel) begin
      got_ov = bus_s.out_valid;
      got_fd = bus_s.frame_done;
      got_w  = {bus_s.w1, bus_s.w2, bus_s.w3,
                bus_s.w4, bus_s.w5, bus_s.w6,
                bus_s.w7, bus_s.w8, bus_s.w9};
    end else begin
      got_ov = bus_m.out_valid;
      got_fd = bus_m.frame_done;
      got_w  = {bus_m.w1, bus_m.w2, bus_m.w3,
                bus_m.w4, bus_m.w5, bus_m.w6,
                bus_m.w7, bus_m.w8, bus_m.w9};
    end
  endtask

  task automatic step(input bit sel, input bit v,
                      input logic [7:0] pix);
    int  w, h, r, c;
    bit  ev, efd;
    w = sel ? 3 : 8;
    h = sel ? 3 : 6;
    @(negedge clk);
    bus_m.in_valid = !sel && v;
    bus_s.in_valid = sel && v;
    bus_m.in_pixel = pix;
    bus_s.in_pixel = pix;
    ev  = 1'b0;
    efd = 1'b0;
    if (v) begin
      r = k / w;
      c = k % w;
      frm[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        for (int i = 0; i < 9; i++)
          exp_w[71-8*i -: 8] = frm[r-2+i/3][c-2+i%3];
      end
      efd = (k == w*h - 1);
      k = (k + 1) % (w*h);
    end
    @(posedge clk);
    #1;
    sample(sel);
    check("out_valid", 72'(got_ov), 72'(ev));
    check("frame_done", 72'(got_fd), 72'(efd));
    if (ev || (!v && w_known))
      check(v ? "window" : "window_hold", got_w, exp_w);
    if (v) w_known = ev;
    ov_cnt += int'(got_ov);
    fd_cnt += int'(got_fd);
  endtask

  task automatic feed(input bit sel, input int pat,
                      input bit gappy, input int npix);
    int w, h, r, c;
    logic [7:0] p;
    w = sel ? 3 : 8;
    h = sel ? 3 : 6;
    ov_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < npix; i++) begin
      r = i / w;
      c = i % w;
      if (gappy && $urandom_range(0, 9) < 3)
        repeat ($urandom_range(1, 2))
          step(sel, 1'b0, 8'($urandom_range(0, 255)));
      case (pat)
        0:       p = 8'(r*16 + c);
        1:       p = 8'hFF - 8'(r*16 + c);
        default: p = 8'($urandom_range(0, 255));
      endcase
      step(sel, 1'b1, p);
      if (pat == 0 && ((!sel && i == 18) || (sel && i == 8)))
        check("first_win", got_w, 72'h000102101112202122);
      if (pat == 0 && !sel && i == 26)
        check("win_r3c2", got_w, 72'h101112202122303132);
      if (pat == 1 && !sel && i == 18)
        check("w5_frame2", 72'(got_w[39:32]), 72'hEE);
    end
    if (npix == w*h) begin
      check("ov_count", 72'(ov_cnt), 72'((w-2)*(h-2)));
      check("fd_count", 72'(fd_cnt), 72'd1);
    end
  endtask

  initial begin
    bus_m.in_valid = 1'b0;
    bus_m.in_pixel = '0;
    bus_s.in_valid = 1'b0;
    bus_s.in_pixel = '0;
    k       = 0;
    w_known = 1'b0;
    exp_w   = '0;
    repeat (3) @(posedge clk);
    #1;
    sample(1'b0);
    check("rst_ov", 72'(got_ov), 72'd0);
    check("rst_fd", 72'(got_fd), 72'd0);
    check("rst_win", got_w, 72'd0);
    sample(1'b1);
    check("rst_min_win", got_w, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;

    feed(1'b0, 0, 1'b0, 48);
    feed(1'b0, 0, 1'b1, 48);
    feed(1'b0, 0, 1'b0, 48);
    feed(1'b0, 1, 1'b0, 48);
    feed(1'b0, 2, 1'b1, 48);

    feed(1'b0, 0, 1'b0, 20);
    #3;
    bus_m.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    sample(1'b0);
    check("midrst_ov", 72'(got_ov), 72'd0);
    check("midrst_fd", 72'(got_fd), 72'd0);
    check("midrst_win", got_w, 72'd0);
    k       = 0;
    w_known = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    feed(1'b0, 0, 1'b0, 48);
    feed(1'b0, 2, 1'b1, 48);

    k       = 0;
    w_known = 1'b0;
    feed(1'b1, 0, 1'b0, 9);
    feed(1'b1, 2, 1'b1, 9);
    feed(1'b1, 1, 1'b0, 9);
    step(1'b1, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator for the edge-preserving / smoothing filter blocks in the haze-removal pipeline.
- Accepts one raster-order pixel per valid cycle and uses two line buffers to build a 3x3 window.
- Presents the nine window pixels in row-major order (w1..w9), which map directly onto the filter blocks' in1..in9 inputs.
- Emits only interior windows. Border pixels produce no output.

Parameters:
- IMG_WIDTH, 512, pixels per line (minimum 3).
- IMG_HEIGHT, 512, lines per frame (minimum 3).
- DATA_W, 8, pixel width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_pixel is valid this cycle. There is no backpressure; the block always accepts.
- in_pixel  input  DATA_W  incoming pixel, raster order, starting at (row 0, col 0).
- out_valid  output  1  w1..w9 hold a valid window this cycle (single-cycle qualifier).
- w1..w9  output  DATA_W each  window pixels in row-major order. w1 = top-left, w5 = centre, w9 = bottom-right.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset:
  - rst_n low asynchronously clears col/row counters, window registers, out_valid, w1..w9 (all 0) and frame_done.
  - Line-buffer contents are not reset. Counter gating guarantees stale contents never reach a valid output.
- Counters:
  - col is 0..IMG_WIDTH-1 and row is 0..IMG_HEIGHT-1, each $clog2-sized.
  - Both advance only on in_valid.
  - col wraps to 0 and row increments at col = IMG_WIDTH-1.
  - row wraps to 0 at the last pixel of the frame.
- Line buffers:
  - Two IMG_WIDTH-deep buffers (LB0 = previous line, LB1 = line before that), read and written at index col.
  - On in_valid:
    - read LB0[col] and LB1[col];
    - write LB1[col] <= LB0[col] and LB0[col] <= in_pixel.
  - Read-before-write at the same address is required.
- Window shift:
  - On in_valid, each window row shifts left by one.
  - New right column: top = LB1[col], middle = LB0[col], bottom = in_pixel.
- Output condition:
  - When the pixel accepted is at (r, c) with r >= 2 and c >= 2, the next cycle has out_valid = 1.
  - That window is centred on (r-1, c-1): w1 = (r-2, c-2) … w9 = (r, c).
- Latency: 1 cycle from accepting pixel (r, c) to its window on w1..w9.
- No window may span a line boundary: pixels at col 0 and col 1 never raise out_valid.
- Valid outputs per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- in_valid gaps:
  - A gap freezes counters, buffers and window.
  - out_valid = 0 during the gap.
  - w1..w9 hold their last values.
- frame_done is high in the cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, coincident with the last out_valid.
- Back-to-back frames:
  - The next frame's pixel (0,0) may arrive in the cycle immediately after the last pixel.
  - No dead cycle is required, and there is no cross-frame contamination.
- Reset mid-frame:
  - out_valid and frame_done drop immediately.
  - The next accepted pixel is treated as (0,0).

Test Plan:
- Directed frame, IMG_WIDTH=8, IMG_HEIGHT=6, pixel = row*16+col, in_valid held high:
  - the first out_valid comes one cycle after the 19th pixel (index 18);
  - w1..w9 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22;
  - exactly 24 out_valid pulses per frame.
- Same frame with pseudo-random in_valid gaps (about 30% idle):
  - identical sequence of 24 windows;
  - out_valid never high during an idle cycle;
  - w1..w9 stable across gaps.
- Line wrap check:
  - no out_valid for pixels at col 0 or 1 of any row;
  - the window after pixel (3,2) is 0x10,0x11,0x12,0x20,0x21,0x22,0x30,0x31,0x32.
- Two back-to-back frames, second frame pixel = 0xFF - (row*16+col):
  - second frame's first window w5 = 0xEE;
  - frame_done pulses exactly once per frame, aligned with that frame's 24th out_valid.
- Reset mid-frame:
  - rst_n low after 20 pixels drops out_valid and w1..w9 to 0 asynchronously;
  - a fresh frame after release yields first window 0x00..0x22 exactly as in the first scenario, with no stale data.
- Minimum size, IMG_WIDTH=3, IMG_HEIGHT=3:
  - exactly one out_valid, after the 9th pixel;
  - window equals the nine input pixels in order;
  - frame_done is in the same cycle.
